// File: rtl/tag_arb_pkg.sv
// Shared types and helpers for the tag sync arbiter directory.
package tag_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MISS_WB,
    REFILL,
    SYNC_SCAN,
    SYNC_WB
  } arb_state_t;

  // Address is widened to 64 bits so one helper serves any ADDR_WIDTH/TAG_LSB.
  function automatic logic [63:0] tag_of(input logic [63:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/lowest_prio_enc.sv
// Lowest-index-first priority encoder: index of the lowest set bit plus any-set flag.
module lowest_prio_enc #(
  parameter int unsigned N = 8,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) begin
        idx = W'(i - 1);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tag_sync_arbiter.sv
// Fully associative tag directory with LRU-by-age replacement and an FSM
// sequencing victim write-back, refill and whole-cache sync.
module tag_sync_arbiter
  import tag_arb_pkg::*;
#(
  parameter int unsigned ENTRY_NUM  = 8,
  parameter int unsigned SEL_WIDTH  = $clog2(ENTRY_NUM),
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_LSB    = 12,
  parameter int unsigned AGE_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          acc_req,
  input  logic                          acc_vwrite,
  input  logic                          acc_write,
  input  logic [ADDR_WIDTH-1:0]         acc_addr,
  output logic                          acc_ready,
  output logic                          hit,
  output logic [SEL_WIDTH-1:0]          hit_sel,
  input  logic                          flush_inv,
  input  logic                          sync_req,
  output logic                          sync_done,
  output logic                          wb_req,
  output logic [SEL_WIDTH-1:0]          wb_sel,
  output logic [ADDR_WIDTH-TAG_LSB-1:0] wb_tag,
  input  logic                          wb_ack,
  output logic                          refill_req,
  output logic [SEL_WIDTH-1:0]          refill_sel,
  input  logic [ADDR_WIDTH-1:0]         refill_pa,
  input  logic                          refill_valid
);

  localparam int unsigned TAG_W = ADDR_WIDTH - TAG_LSB;

  arb_state_t           state, state_nxt;
  logic [ENTRY_NUM-1:0] valid, dirty;
  logic [TAG_W-1:0]     tags [ENTRY_NUM];
  logic [AGE_WIDTH-1:0] ages [ENTRY_NUM];
  logic [SEL_WIDTH-1:0] victim, victim_c;
  logic                 sync_done_q;

  logic [TAG_W-1:0]     acc_tag, refill_tag;
  logic [ENTRY_NUM-1:0] hit_vec, max_vec, dirty_vec;
  logic [AGE_WIDTH-1:0] max_age;
  logic [SEL_WIDTH-1:0] hit_idx, inv_idx, age_idx, dirty_idx;
  logic                 hit_any, inv_any, age_any, dirty_any;
  logic                 idle, accepted, touch_en;
  logic [SEL_WIDTH-1:0] touch_sel;

  // Write-through writes leave no directory state behind.
  logic unused_sig;
  assign unused_sig = ^{acc_write, age_any};

  assign acc_tag    = TAG_W'(tag_of(64'(acc_addr), TAG_LSB));
  assign refill_tag = TAG_W'(tag_of(64'(refill_pa), TAG_LSB));
  assign dirty_vec  = valid & dirty;

  always_comb begin
    hit_vec = '0;
    max_vec = '0;
    max_age = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      hit_vec[i] = valid[i] && (tags[i] == acc_tag);
      if (ages[i] > max_age) max_age = ages[i];
    end
    for (int unsigned i = 0; i < ENTRY_NUM; i++)
      max_vec[i] = valid[i] && (ages[i] == max_age);
  end

  lowest_prio_enc #(.N(ENTRY_NUM)) u_hit_enc   (.vec(hit_vec),   .idx(hit_idx),   .any(hit_any));
  lowest_prio_enc #(.N(ENTRY_NUM)) u_inv_enc   (.vec(~valid),    .idx(inv_idx),   .any(inv_any));
  lowest_prio_enc #(.N(ENTRY_NUM)) u_age_enc   (.vec(max_vec),   .idx(age_idx),   .any(age_any));
  lowest_prio_enc #(.N(ENTRY_NUM)) u_dirty_enc (.vec(dirty_vec), .idx(dirty_idx), .any(dirty_any));

  assign idle      = (state == IDLE);
  assign acc_ready = idle && !flush_inv && !sync_req;
  assign accepted  = acc_req && acc_ready;
  assign hit       = accepted && hit_any;
  assign hit_sel   = hit_idx;
  assign victim_c  = inv_any ? inv_idx : age_idx;

  assign wb_req     = (state == MISS_WB) || (state == SYNC_WB);
  assign wb_sel     = victim;
  assign wb_tag     = tags[victim];
  assign refill_req = (state == REFILL);
  assign refill_sel = victim;
  assign sync_done  = sync_done_q;

  // Hits and refill installs share one aging pass: selected entry to 0, other valid entries +1.
  assign touch_en  = (accepted && hit_any) || (refill_req && refill_valid);
  assign touch_sel = refill_req ? victim : hit_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush_inv)                state_nxt = IDLE;
        else if (sync_req)            state_nxt = SYNC_SCAN;
        else if (accepted && !hit_any)
          state_nxt = (valid[victim_c] && dirty[victim_c]) ? MISS_WB : REFILL;
      end
      MISS_WB:   if (wb_ack) state_nxt = REFILL;
      REFILL:    if (refill_valid) state_nxt = IDLE;
      SYNC_SCAN: state_nxt = dirty_any ? SYNC_WB : IDLE;
      SYNC_WB:   if (wb_ack) state_nxt = SYNC_SCAN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      victim      <= '0;
      sync_done_q <= 1'b0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        tags[i] <= '0;
        ages[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      sync_done_q <= (state == SYNC_SCAN) && !dirty_any;

      if (touch_en) begin
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
          if (SEL_WIDTH'(i) == touch_sel) ages[i] <= '0;
          else if (valid[i] && !(&ages[i])) ages[i] <= ages[i] + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (flush_inv) begin
            valid <= '0;
            dirty <= '0;
            for (int unsigned i = 0; i < ENTRY_NUM; i++) ages[i] <= '0;
          end else if (accepted) begin
            if (hit_any) begin
              if (acc_vwrite) dirty[hit_idx] <= 1'b1;
            end else begin
              victim <= victim_c;
            end
          end
        end
        MISS_WB: if (wb_ack) dirty[victim] <= 1'b0;
        REFILL: begin
          if (refill_valid) begin
            tags[victim]  <= refill_tag;
            valid[victim] <= 1'b1;
            dirty[victim] <= 1'b0;
          end
        end
        SYNC_SCAN: if (dirty_any) victim <= dirty_idx;
        SYNC_WB:   if (wb_ack) dirty[victim] <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tag_sync_arbiter.md
# tag_sync_arbiter

Fully associative tag directory with LRU-by-age replacement, per-entry valid and dirty state, and a sequencing FSM that owns victim write-back, refill and whole-cache sync. It is the successor to the BIU's first-generation tag arbiter. Entry count, address split and age width are parameters. Dirty-victim write-back and force-sync are sequenced internally over a req/ack handshake instead of being left to the BIU. It sits between the core/VPU access port and the BIU refill/write-back engine.

## Interface
- ENTRY_NUM, 8, directory entries (≥2)
- SEL_WIDTH, $clog2(ENTRY_NUM), entry index width
- ADDR_WIDTH, 32, access/physical address width
- TAG_LSB, 12, lowest tag bit; tag = addr[ADDR_WIDTH-1:TAG_LSB]
- AGE_WIDTH, 4, per-entry age counter width (≥SEL_WIDTH)
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- acc_req  in  1  core/VPU lookup request
- acc_vwrite  in  1  VPU write-back-policy write; marks the line dirty on hit
- acc_write  in  1  CPU write-through write; never sets dirty
- acc_addr  in  ADDR_WIDTH  access address
- acc_ready  out  1  directory idle; accesses accepted
- hit  out  1  accepted access hit a valid entry
- hit_sel  out  SEL_WIDTH  hitting entry (lowest index if multiple)
- flush_inv  in  1  invalidate all entries, discard dirty
- sync_req  in  1  write back every dirty entry
- sync_done  out  1  one-cycle pulse: sync finished
- wb_req  out  1  write-back request to BIU
- wb_sel  out  SEL_WIDTH  entry to write back
- wb_tag  out  ADDR_WIDTH-TAG_LSB  tag of that entry
- wb_ack  in  1  write-back complete
- refill_req  out  1  refill request to BIU
- refill_sel  out  SEL_WIDTH  entry being refilled
- refill_pa  in  ADDR_WIDTH  refill physical address
- refill_valid  in  1  refill data written; install tag

## Operation
- States: IDLE, MISS_WB, REFILL, SYNC_SCAN, SYNC_WB.
- IDLE: acc_ready=1.
  - Accepted access = acc_req & acc_ready.
  - hit = accepted & some valid entry's tag equals acc_addr tag.
- Hit update, next edge:
  - Hit entry age <= 0.
  - Every other valid entry age <= age+1, saturating at 2^AGE_WIDTH-1.
  - acc_vwrite also sets the hit entry's dirty bit.
- Miss (accepted & !hit): victim is latched the same edge.
  - Victim = lowest-index invalid entry; else lowest-index entry with maximum age.
  - Victim dirty → MISS_WB. Otherwise → REFILL.
  - The access address is not retained. The requester re-issues after acc_ready returns.
- MISS_WB:
  - wb_req=1, wb_sel=victim, wb_tag=victim tag.
  - On wb_ack, clear victim dirty → REFILL.
- REFILL:
  - refill_req=1, refill_sel=victim.
  - On refill_valid, next edge: tag <= refill_pa tag, valid=1, dirty=0, age=0; every other valid entry ages +1 (saturating) → IDLE.
- IDLE priority, highest first: flush_inv > sync_req > access.
  - flush_inv: all valid and dirty <= 0, ages <= 0; stay IDLE; acc_ready=0 that cycle.
  - sync_req → SYNC_SCAN.
- SYNC_SCAN:
  - Any valid dirty entry → latch the lowest-index one → SYNC_WB.
  - Else pulse sync_done → IDLE.
- SYNC_WB: wb_req as in MISS_WB; on wb_ack clear that entry's dirty → SYNC_SCAN.
- Outside IDLE, flush_inv, sync_req and acc_req are ignored; requesters must hold them.
- refill_valid outside REFILL and wb_ack outside MISS_WB/SYNC_WB are ignored.

## Timing
- Reset values:
  - State IDLE; valid, dirty and age all 0.
  - acc_ready=1; hit=0, sync_done=0, wb_req=0, refill_req=0.
  - hit_sel, wb_sel, refill_sel=0; wb_tag=0.
- hit and hit_sel are combinational from acc_addr; state updates on the next edge.
- wb_req and refill_req are registered state decodes. They rise one cycle after the triggering edge and stay high through the cycle in which wb_ack/refill_valid is sampled.
- wb_ack or refill_valid may be high in the first request cycle (minimum 1-cycle handshake).
- Clean miss → refill_req on the next cycle. Dirty miss → wb_req first.
- Sync with no dirty lines: sync_done 2 cycles after sync_req.
- rst mid-operation aborts any handshake: wb_req and refill_req drop the next cycle; contents are cleared.

## Structure
- Shared package `tag_arb_pkg`:
  - state encoding constants;
  - function tag_of(addr).
- One sub-module `lowest_prio_enc #(N)`: N-bit vector in, index plus any-set out.
  - Instantiated for hit select, invalid-victim select, max-age-victim select and dirty select.

## Test plan
- After reset, access 0x0000_3000 → miss; refill_req, refill_sel=0; refill_valid with 0x0000_3000 → next access 0x0000_3ABC gives hit=1, hit_sel=0.
- Fill all 8 entries (tags 1..8), then re-hit entries 1..7 → next miss has victim entry 0 (max age); refill_sel=0, no wb_req.
- acc_vwrite hit on entry 2, then force entry 2 as victim → wb_req, wb_sel=2, wb_tag matches; wb_ack → refill_req next cycle; dirty[2]=0 after refill.
- Dirty entries 1, 4, 6; sync_req → wb_sel sequence 1, 4, 6 → sync_done pulses exactly once → acc_ready=1.
- flush_inv and sync_req in the same IDLE cycle → all invalid and clean, no wb_req, no sync_done; a subsequent access misses.
- rst asserted while wb_req is high → wb_req=0 next cycle, acc_ready=1, all entries invalid; any late wb_ack is ignored.
